// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral and its scheduler.
// Register map, control bits and scheduler FSM states.
package timer_pkg;

    localparam logic [31:0] TMR_STATUS   = 32'h0000_0000;
    localparam logic [31:0] TMR_CONTROL  = 32'h0000_0004;
    localparam logic [31:0] TMR_PERIOD   = 32'h0000_0008;
    localparam logic [31:0] TMR_SNAPSHOT = 32'h0000_000C;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // One-shot start with interrupt enabled
    localparam logic [31:0] CTL_ONESHOT =
        (32'd1 << CTL_ITO) | (32'd1 << CTL_START);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WR_PER,
        WR_CTL,
        WAIT_INT,
        WR_CLR,
        FIN
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
// The pointer only moves when the owner commits a winner.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    input  logic [IW-1:0]   win,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] jj;
    logic          found;

    // Last-winner pointer; reset value makes requester 0 win first
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ptr <= IW'(NREQ - 1);
        end else if (adv) begin
            ptr <= win;
        end
    end

    // First active request at or after ptr+1, wrapping around
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        jj    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            jj = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/timer_sched.sv
// Shares one timer among NREQ requesters: arbitrates, programs the
// timer over Wishbone, waits for its interrupt and reports completion.
module timer_sched
    import timer_pkg::*;
#(
    parameter int          NREQ       = 4,
    parameter int          LEN_WIDTH  = 16,
    parameter logic [31:0] TIMER_BASE = 32'h0,
    parameter int          ACK_TMO    = 15
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic [NREQ-1:0]           REQ_I,
    input  logic [NREQ*LEN_WIDTH-1:0] LEN_I,
    output logic [NREQ-1:0]           DONE_O,
    output logic                      ERR_O,
    output logic                      BUSY_O,
    output logic [31:0]               M_ADR_O,
    output logic [31:0]               M_DAT_O,
    output logic                      M_WE_O,
    output logic                      M_STB_O,
    output logic                      M_CYC_O,
    output logic [3:0]                M_SEL_O,
    output logic [2:0]                M_CTI_O,
    output logic [1:0]                M_BTE_O,
    output logic                      M_LOCK_O,
    input  logic [31:0]               M_DAT_I,
    input  logic                      M_ACK_I,
    input  logic                      TMR_INT_I
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(ACK_TMO + 1);

    sched_state_t         state;
    logic [IW-1:0]        win;
    logic [NREQ-1:0]      win_oh;
    logic                 ph;
    logic [CW-1:0]        cnt;
    logic                 err_q;
    logic [NREQ-1:0]      req_m;
    logic [NREQ-1:0]      arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_any;
    logic [LEN_WIDTH-1:0] sel_len;
    logic                 unused_ok;

    // The requester just completed is ignored while DONE_O is high
    assign req_m = REQ_I & ~DONE_O;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .req  (req_m),
        .adv  (state == FIN),
        .win  (win),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // Tick count of the requester the arbiter is pointing at
    always_comb begin
        sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_len = LEN_I[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign BUSY_O    = (state != IDLE);
    assign M_SEL_O   = 4'hF;
    assign M_CTI_O   = 3'd0;
    assign M_BTE_O   = 2'd0;
    assign M_LOCK_O  = 1'b0;
    assign unused_ok = ^M_DAT_I;

    // Sequencer plus inline Wishbone write engine (ph=1 is the idle gap)
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state   <= IDLE;
            win     <= '0;
            win_oh  <= '0;
            ph      <= 1'b0;
            cnt     <= '0;
            err_q   <= 1'b0;
            DONE_O  <= '0;
            ERR_O   <= 1'b0;
            M_CYC_O <= 1'b0;
            M_STB_O <= 1'b0;
            M_WE_O  <= 1'b0;
            M_ADR_O <= '0;
            M_DAT_O <= '0;
        end else begin
            DONE_O <= '0;
            ERR_O  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_m) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (!arb_any) begin
                        state <= IDLE;
                    end else begin
                        win    <= arb_idx;
                        win_oh <= arb_gnt;
                        err_q  <= 1'b0;
                        if (sel_len == '0) begin
                            state <= FIN;
                        end else begin
                            state   <= WR_PER;
                            M_CYC_O <= 1'b1;
                            M_STB_O <= 1'b1;
                            M_WE_O  <= 1'b1;
                            M_ADR_O <= TIMER_BASE + TMR_PERIOD;
                            M_DAT_O <= 32'(sel_len);
                            cnt     <= '0;
                            ph      <= 1'b0;
                        end
                    end
                end
                WR_PER, WR_CTL, WR_CLR: begin
                    if (!ph) begin
                        if (M_ACK_I) begin
                            M_CYC_O <= 1'b0;
                            M_STB_O <= 1'b0;
                            M_WE_O  <= 1'b0;
                            ph      <= 1'b1;
                        end else if (cnt == CW'(ACK_TMO - 1)) begin
                            M_CYC_O <= 1'b0;
                            M_STB_O <= 1'b0;
                            M_WE_O  <= 1'b0;
                            err_q   <= 1'b1;
                            state   <= FIN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        ph <= 1'b0;
                        unique case (state)
                            WR_PER: begin
                                state   <= WR_CTL;
                                M_CYC_O <= 1'b1;
                                M_STB_O <= 1'b1;
                                M_WE_O  <= 1'b1;
                                M_ADR_O <= TIMER_BASE + TMR_CONTROL;
                                M_DAT_O <= CTL_ONESHOT;
                                cnt     <= '0;
                            end
                            WR_CTL:  state <= WAIT_INT;
                            default: state <= FIN;
                        endcase
                    end
                end
                WAIT_INT: begin
                    if (TMR_INT_I) begin
                        state   <= WR_CLR;
                        M_CYC_O <= 1'b1;
                        M_STB_O <= 1'b1;
                        M_WE_O  <= 1'b1;
                        M_ADR_O <= TIMER_BASE + TMR_STATUS;
                        M_DAT_O <= 32'd0;
                        cnt     <= '0;
                        ph      <= 1'b0;
                    end
                end
                FIN: begin
                    DONE_O <= win_oh;
                    ERR_O  <= err_q;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Randomized scoreboard bench for timer_sched with a timer slave model.
// Expected grants and bus writes are queued; monitors pop and compare.
module tb_timer_sched;

    localparam int          NREQ = 4;
    localparam int          LW   = 16;
    localparam int          TMO  = 15;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct { int idx; bit err; } grant_t;
    typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;

    logic                 CLK_I = 1'b0;
    logic                 RST_I = 1'b1;
    logic [NREQ-1:0]      REQ_I = '0;
    logic [NREQ*LW-1:0]   LEN_I = '0;
    logic [NREQ-1:0]      DONE_O;
    logic                 ERR_O, BUSY_O;
    logic [31:0]          M_ADR_O, M_DAT_O;
    logic                 M_WE_O, M_STB_O, M_CYC_O;
    logic [3:0]           M_SEL_O;
    logic [2:0]           M_CTI_O;
    logic [1:0]           M_BTE_O;
    logic                 M_LOCK_O;
    logic [31:0]          M_DAT_I = 32'hDEAD_BEEF;
    logic                 M_ACK_I = 1'b0;
    logic                 TMR_INT_I = 1'b0;

    int checks = 0;
    int failures = 0;
    grant_t exp_q[$];
    wr_t    exp_wr[$];
    int  mptr = NREQ - 1;
    bit  ack_en = 1'b1;
    int  ack_delay = 1;
    bit  auto_drop = 1'b0;
    logic [NREQ-1:0] done_prev = '0;
    int  tmo_runs = 0;
    int  stb_starts = 0;
    bit  ctl_seen = 1'b0;

    timer_sched #(
        .NREQ(NREQ), .LEN_WIDTH(LW), .TIMER_BASE(BASE), .ACK_TMO(TMO)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .REQ_I(REQ_I), .LEN_I(LEN_I),
        .DONE_O(DONE_O), .ERR_O(ERR_O), .BUSY_O(BUSY_O),
        .M_ADR_O(M_ADR_O), .M_DAT_O(M_DAT_O), .M_WE_O(M_WE_O),
        .M_STB_O(M_STB_O), .M_CYC_O(M_CYC_O), .M_SEL_O(M_SEL_O),
        .M_CTI_O(M_CTI_O), .M_BTE_O(M_BTE_O), .M_LOCK_O(M_LOCK_O),
        .M_DAT_I(M_DAT_I), .M_ACK_I(M_ACK_I), .TMR_INT_I(TMR_INT_I)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference round robin: first requester after the last winner
    function automatic int rr_next(logic [NREQ-1:0] s);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (mptr + k) % NREQ;
            if (s[j]) begin
                mptr = j;
                return j;
            end
        end
        return -1;
    endfunction

    task automatic push_grant(int idx, int len, bit tmo);
        grant_t g;
        wr_t w;
        g.idx = idx;
        g.err = tmo && (len != 0);
        exp_q.push_back(g);
        if (len != 0 && !tmo) begin
            w.adr = BASE + 32'h8; w.dat = 32'(len); exp_wr.push_back(w);
            w.adr = BASE + 32'h4; w.dat = 32'h5;    exp_wr.push_back(w);
            w.adr = BASE + 32'h0; w.dat = 32'h0;    exp_wr.push_back(w);
        end
    endtask

    task automatic set_len(int i, int v);
        LEN_I[i*LW +: LW] = LW'(v);
    endtask

    task automatic wait_done(output int idx);
        idx = -1;
        for (int n = 0; n < 600 && idx < 0; n++) begin
            @(negedge CLK_I);
            for (int i = 0; i < NREQ; i++)
                if (DONE_O[i]) idx = i;
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_done: no DONE_O within 600 cycles");
        end
        @(posedge CLK_I);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_done"}, 64'(DONE_O), 64'h0);
        chk({tag, "_err"}, 64'(ERR_O), 64'h0);
        chk({tag, "_busy"}, 64'(BUSY_O), 64'h0);
        chk({tag, "_cyc_stb_we"}, 64'({M_CYC_O, M_STB_O, M_WE_O}), 64'h0);
        chk({tag, "_adr"}, 64'(M_ADR_O), 64'h0);
        chk({tag, "_dat"}, 64'(M_DAT_O), 64'h0);
    endtask

    // Requesters drop REQ_I in the cycle after their DONE_O
    initial begin
        forever begin
            @(posedge CLK_I);
            #1;
            if (auto_drop) REQ_I = REQ_I & ~done_prev;
            done_prev = DONE_O;
        end
    end

    // Completion monitor: pop expected grant on every DONE_O/ERR_O
    initial begin
        grant_t e;
        logic [NREQ-1:0] eo;
        forever begin
            @(negedge CLK_I);
            if (DONE_O != '0 || ERR_O) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got %b err=%b expected none",
                             DONE_O, ERR_O);
                end else begin
                    e = exp_q.pop_front();
                    eo = '0;
                    eo[e.idx] = 1'b1;
                    chk("done_onehot", 64'(DONE_O), 64'(eo));
                    chk("err_flag", 64'(ERR_O), 64'(e.err));
                end
            end
        end
    end

    // Timer slave model: Wishbone acks, register effects, countdown
    initial begin
        int stb_run = 0;
        int wait_n = 0;
        int t_cnt = 0;
        int t_period = 0;
        bit t_run = 0;
        wr_t w;
        forever begin
            @(negedge CLK_I);
            if (t_run) begin
                if (t_cnt <= 1) begin
                    TMR_INT_I = 1'b1;
                    t_run = 0;
                end else begin
                    t_cnt--;
                end
            end
            if (M_ACK_I) begin
                M_ACK_I = 1'b0;
                chk("idle_gap_after_ack", 64'(M_STB_O), 64'h0);
                stb_run = 0;
                wait_n = 0;
            end else if (M_CYC_O && M_STB_O) begin
                if (stb_run == 0) stb_starts++;
                stb_run++;
                if (ack_en && wait_n >= ack_delay) begin
                    M_ACK_I = 1'b1;
                    checks++;
                    if (exp_wr.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: got adr %0h dat %0h expected none",
                                 M_ADR_O, M_DAT_O);
                    end else begin
                        w = exp_wr.pop_front();
                        if (M_ADR_O !== w.adr || M_DAT_O !== w.dat ||
                            M_WE_O !== 1'b1 || M_SEL_O !== 4'hF) begin
                            failures++;
                            $display("FAIL bus_write: got adr %0h dat %0h we %b sel %h expected adr %0h dat %0h",
                                     M_ADR_O, M_DAT_O, M_WE_O, M_SEL_O, w.adr, w.dat);
                        end
                    end
                    if (M_ADR_O == BASE + 32'h8) t_period = int'(M_DAT_O[LW-1:0]);
                    if (M_ADR_O == BASE + 32'h4) begin
                        ctl_seen = 1'b1;
                        if (M_DAT_O[2]) begin
                            t_cnt = t_period;
                            t_run = 1;
                        end
                    end
                    if (M_ADR_O == BASE && !M_DAT_O[0]) TMR_INT_I = 1'b0;
                end else begin
                    wait_n++;
                end
            end else begin
                if (stb_run > 0) begin
                    tmo_runs++;
                    chk("strobe_timeout_len", 64'(stb_run), 64'(TMO));
                end
                stb_run = 0;
                wait_n = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int s0;
        int t0;
        int lens[NREQ];
        logic [NREQ-1:0] set;
        bit tmo;

        RST_I = 1'b1;
        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        check_reset_outputs("rst");
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;

        // All four held, equal lengths: 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_len(i, 3);
        for (int k = 0; k < 5; k++) push_grant(rr_next(4'b1111), 3, 0);
        REQ_I = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(id);
        REQ_I = '0;
        repeat (3) @(posedge CLK_I);
        #1;

        // Requester 1 re-requests right away while 3 is pending
        set_len(1, 4);
        set_len(3, 6);
        push_grant(rr_next(4'b1010), 4, 0);
        push_grant(rr_next(4'b1010), 6, 0);
        push_grant(rr_next(4'b0010), 4, 0);
        REQ_I = 4'b1010;
        wait_done(id);
        wait_done(id);
        REQ_I[3] = 1'b0;
        wait_done(id);
        REQ_I[1] = 1'b0;
        repeat (3) @(posedge CLK_I);
        #1;

        // Single requester, LEN=20
        ack_delay = 1;
        set_len(0, 20);
        push_grant(rr_next(4'b0001), 20, 0);
        REQ_I = 4'b0001;
        @(negedge CLK_I);
        chk("stb_low_idle", 64'(M_STB_O), 64'h0);
        @(posedge CLK_I);
        @(posedge CLK_I);
        @(negedge CLK_I);
        chk("req_to_stb_latency", 64'(M_STB_O), 64'h1);
        chk("first_write_adr", 64'(M_ADR_O), 64'(BASE + 32'h8));
        wait_done(id);
        REQ_I[0] = 1'b0;
        @(negedge CLK_I);
        chk("busy_low_after_done", 64'(BUSY_O), 64'h0);
        repeat (2) @(posedge CLK_I);
        #1;

        // LEN=0 on requester 2: DONE 3 cycles after request, no bus
        set_len(2, 0);
        push_grant(rr_next(4'b0100), 0, 0);
        s0 = stb_starts;
        REQ_I = 4'b0100;
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        chk("len0_not_early", 64'(DONE_O), 64'h0);
        @(posedge CLK_I);
        @(negedge CLK_I);
        chk("len0_done_at_3", 64'(DONE_O), 64'h4);
        @(posedge CLK_I);
        #1;
        REQ_I[2] = 1'b0;
        repeat (2) @(posedge CLK_I);
        chk("len0_no_strobe", 64'(stb_starts - s0), 64'h0);
        #1;

        // No ACK: strobe drops after TMO cycles, DONE with ERR
        ack_en = 1'b0;
        t0 = tmo_runs;
        set_len(3, 7);
        push_grant(rr_next(4'b1000), 7, 1);
        REQ_I = 4'b1000;
        wait_done(id);
        REQ_I = '0;
        chk("timeout_runs", 64'(tmo_runs - t0), 64'h1);
        ack_en = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;

        // Reset while waiting for the interrupt
        set_len(0, 40);
        push_grant(0, 40, 0);
        void'(exp_wr.pop_back());
        void'(exp_q.pop_back());
        ctl_seen = 1'b0;
        REQ_I = 4'b0001;
        for (int n = 0; n < 200 && !ctl_seen; n++) @(posedge CLK_I);
        chk("ctl_write_seen", 64'(ctl_seen), 64'h1);
        repeat (5) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        REQ_I = '0;
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        mptr = NREQ - 1;
        @(negedge CLK_I);
        check_reset_outputs("midrst");
        repeat (3) @(posedge CLK_I);
        #1;
        set_len(0, 6);
        push_grant(rr_next(4'b0001), 6, 0);
        REQ_I = 4'b0001;
        wait_done(id);
        REQ_I = '0;
        repeat (3) @(posedge CLK_I);
        #1;

        // Randomized batches of simultaneous requests
        auto_drop = 1'b1;
        for (int b = 0; b < 30; b++) begin
            int n;
            set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            tmo = ($urandom_range(0, 7) == 0);
            ack_en = !tmo;
            ack_delay = $urandom_range(0, 3);
            for (int i = 0; i < NREQ; i++) begin
                lens[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
                set_len(i, lens[i]);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (set[i]) begin
                    logic [NREQ-1:0] rem;
                    rem = '0;
                    for (int j = 0; j < NREQ; j++)
                        if (set[j]) rem[j] = 1'b1;
                    break;
                end
            end
            begin
                logic [NREQ-1:0] rem;
                rem = set;
                while (rem != '0) begin
                    int g;
                    g = rr_next(rem);
                    push_grant(g, lens[g], tmo);
                    rem[g] = 1'b0;
                end
            end
            REQ_I = set;
            n = 0;
            while ((exp_q.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
                @(negedge CLK_I);
                n++;
            end
            chk("batch_drain", 64'(exp_q.size() + exp_wr.size()), 64'h0);
            if (exp_q.size() != 0 || exp_wr.size() != 0) begin
                exp_q.delete();
                exp_wr.delete();
                @(posedge CLK_I);
                #1;
                RST_I = 1'b1;
                REQ_I = '0;
                @(posedge CLK_I);
                #1;
                RST_I = 1'b0;
                mptr = NREQ - 1;
            end
            repeat (4) @(posedge CLK_I);
            #1;
            chk("batch_req_released", 64'(REQ_I), 64'h0);
            ack_en = 1'b1;
        end
        auto_drop = 1'b0;

        repeat (5) @(posedge CLK_I);
        chk("final_queues_empty", 64'(exp_q.size() + exp_wr.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
